// File: rtl/cpu_types_pkg.sv
// Shared datapath types: word width, opcode encoding and the memory-stage FSM states.
package cpu_types_pkg;

    localparam int unsigned WORD_W = 32;
    localparam int unsigned OP_W   = 6;

    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic [OP_W-1:0] {
        RTYPE = 6'h00,
        LW    = 6'h23,
        SW    = 6'h2B,
        LL    = 6'h30,
        SC    = 6'h38
    } opcode_t;

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} memstate_t;

endpackage

// File: rtl/mem_stage_llsc_link.sv
// LL/SC link register: set by LL, cleared by stores, dropped on a matching coherence invalidation.
module llsc_link
    import cpu_types_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  set,
    input  logic  clr,
    input  word_t set_addr,
    input  logic  inval,
    input  word_t inval_addr,
    input  word_t query_addr,
    output logic  hit_c
);

    logic  valid;
    word_t link_addr;
    logic  inval_hit_c;

    assign inval_hit_c = inval && (inval_addr == link_addr);

    // An invalidation in the same cycle kills the reservation for the querying SC.
    assign hit_c = valid && (query_addr == link_addr) && !inval_hit_c;

    // Priority: LL set beats store clear beats invalidation.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid     <= 1'b0;
            link_addr <= '0;
        end else if (set) begin
            valid     <= 1'b1;
            link_addr <= set_addr;
        end else if (clr || inval_hit_c) begin
            valid     <= 1'b0;
        end
    end

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage: drives the dcache, holds the access until dhit and stalls the pipe.
// Optional LL/SC link support is built when LLSC_EN is defined.
module mem_stage
    import cpu_types_pkg::*;
(
    input  logic    CLK,
    input  logic    RST,
    input  logic    memREN,
    input  logic    memWEN,
    input  opcode_t opcode,
    input  word_t   addr,
    input  word_t   storedata,
    input  logic    flush,
    input  logic    dhit,
    input  word_t   dmemload,
    output logic    dmemREN,
    output logic    dmemWEN,
    output word_t   dmemaddr,
    output word_t   dmemstore,
    output word_t   loaddata,
    output logic    memwait,
    output logic    mem_done,
    input  logic    link_inval,
    input  word_t   link_inval_addr
);

    memstate_t state, next_state;
    logic      req_c;
    logic      complete_c;
    logic      sc_abort_c;
    logic      is_sc_c;
    logic      sc_ok_c;
    logic      sc_fail_c;

    assign req_c = (memREN || memWEN) && !flush;

`ifdef LLSC_EN
    logic is_ll_c;

    assign is_ll_c   = memREN && (opcode == LL);
    assign is_sc_c   = memWEN && (opcode == SC);
    assign sc_fail_c = is_sc_c && !sc_ok_c;

    llsc_link u_link (
        .clk        (CLK),
        .rst        (RST),
        .set        (complete_c && is_ll_c),
        .clr        (complete_c && memWEN),
        .set_addr   (addr),
        .inval      (link_inval),
        .inval_addr (link_inval_addr),
        .query_addr (addr),
        .hit_c      (sc_ok_c)
    );
`else
    logic unused_llsc;

    assign is_sc_c     = 1'b0;
    assign sc_ok_c     = 1'b0;
    assign sc_fail_c   = 1'b0;
    assign unused_llsc = ^{opcode, link_inval, link_inval_addr};
`endif

    // Next state and cache strobes; everything is held low while reset is asserted.
    always_comb begin
        next_state = state;
        dmemREN    = 1'b0;
        dmemWEN    = 1'b0;
        dmemaddr   = '0;
        dmemstore  = '0;
        memwait    = 1'b0;
        mem_done   = 1'b0;
        complete_c = 1'b0;
        sc_abort_c = 1'b0;
        if (!RST) begin
            unique case (state)
                IDLE: begin
                    if (req_c) begin
                        memwait = 1'b1;
                        if (sc_fail_c) begin
                            sc_abort_c = 1'b1;
                            next_state = DONE;
                        end else begin
                            dmemREN    = memREN;
                            dmemWEN    = memWEN;
                            dmemaddr   = addr;
                            dmemstore  = storedata;
                            complete_c = dhit;
                            next_state = dhit ? DONE : ACCESS;
                        end
                    end
                end
                ACCESS: begin
                    // EX/MEM is stalled, so its outputs still describe this access.
                    memwait    = 1'b1;
                    dmemREN    = memREN;
                    dmemWEN    = memWEN;
                    dmemaddr   = addr;
                    dmemstore  = storedata;
                    complete_c = dhit;
                    if (dhit) begin
                        next_state = DONE;
                    end
                end
                DONE: begin
                    mem_done   = 1'b1;
                    next_state = IDLE;
                end
                default: next_state = IDLE;
            endcase
        end
    end

    // State register and load/SC result capture.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= IDLE;
            loaddata <= '0;
        end else begin
            state <= next_state;
            if (complete_c && memREN) begin
                loaddata <= dmemload;
            end else if (complete_c && is_sc_c) begin
                loaddata <= WORD_W'(sc_ok_c);
            end else if (sc_abort_c) begin
                loaddata <= '0;
            end
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage; LL/SC sequences run when LLSC_EN is defined.
module tb_mem_stage;
    import cpu_types_pkg::*;

    logic    clk = 1'b0;
    logic    rst;
    logic    mem_ren, mem_wen, flush, dhit, link_inval;
    opcode_t opcode;
    word_t   addr, storedata, dmemload, link_inval_addr;
    logic    dmem_ren, dmem_wen, memwait, mem_done;
    word_t   dmemaddr, dmemstore, loaddata;

    int vectors = 0;
    int errors  = 0;

    always #5 clk = ~clk;

    mem_stage dut (
        .CLK             (clk),
        .RST             (rst),
        .memREN          (mem_ren),
        .memWEN          (mem_wen),
        .opcode          (opcode),
        .addr            (addr),
        .storedata       (storedata),
        .flush           (flush),
        .dhit            (dhit),
        .dmemload        (dmemload),
        .dmemREN         (dmem_ren),
        .dmemWEN         (dmem_wen),
        .dmemaddr        (dmemaddr),
        .dmemstore       (dmemstore),
        .loaddata        (loaddata),
        .memwait         (memwait),
        .mem_done        (mem_done),
        .link_inval      (link_inval),
        .link_inval_addr (link_inval_addr)
    );

    task automatic check(input string tag, input word_t obs, input word_t exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Apply one EX/MEM request plus cache response, then let combinational outputs settle.
    task automatic drive(input logic ren, input logic wen, input opcode_t op, input word_t a,
                         input word_t sd, input logic hit, input word_t ld);
        mem_ren   = ren;
        mem_wen   = wen;
        opcode    = op;
        addr      = a;
        storedata = sd;
        dhit      = hit;
        dmemload  = ld;
        #1;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, RTYPE, '0, '0, 1'b0, '0);
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; link_inval = 1'b0; link_inval_addr = '0;
        idle();
        tick();
        check("rst_loaddata", loaddata, 32'h0);
        check("rst_memwait", 32'(memwait), 32'h0);
        check("rst_mem_done", 32'(mem_done), 32'h0);
        check("rst_dmemREN", 32'(dmem_ren), 32'h0);
        rst = 1'b0;
        tick();

        // LW 0x100, hit in issue cycle
        drive(1'b1, 1'b0, LW, 32'h100, '0, 1'b1, 32'hDEADBEEF);
        check("lw_dmemREN", 32'(dmem_ren), 32'h1);
        check("lw_dmemaddr", dmemaddr, 32'h100);
        check("lw_memwait", 32'(memwait), 32'h1);
        check("lw_no_done_early", 32'(mem_done), 32'h0);
        tick();
        drive(1'b1, 1'b0, LW, 32'h100, '0, 1'b0, '0);
        check("lw_done", 32'(mem_done), 32'h1);
        check("lw_done_memwait", 32'(memwait), 32'h0);
        check("lw_done_no_strobe", 32'(dmem_ren), 32'h0);
        check("lw_loaddata", loaddata, 32'hDEADBEEF);
        tick();
        idle();
        check("lw_done_pulse", 32'(mem_done), 32'h0);

        // SW 0x200 with dhit on the 4th cycle
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b1, SW, 32'h200, 32'h1234, (i == 3), '0);
            check("sw_dmemWEN", 32'(dmem_wen), 32'h1);
            check("sw_dmemstore", dmemstore, 32'h1234);
            check("sw_dmemaddr", dmemaddr, 32'h200);
            check("sw_memwait", 32'(memwait), 32'h1);
            check("sw_no_done", 32'(mem_done), 32'h0);
            tick();
        end
        drive(1'b0, 1'b1, SW, 32'h200, 32'h1234, 1'b0, '0);
        check("sw_done", 32'(mem_done), 32'h1);
        check("sw_done_no_strobe", 32'(dmem_wen), 32'h0);
        check("sw_loaddata_kept", loaddata, 32'hDEADBEEF);
        tick();

        // flush in IDLE suppresses the request
        flush = 1'b1;
        drive(1'b1, 1'b0, LW, 32'h400, '0, 1'b0, '0);
        check("flush_idle_strobe", 32'(dmem_ren), 32'h0);
        check("flush_idle_memwait", 32'(memwait), 32'h0);
        tick();
        flush = 1'b0;
        idle();
        check("flush_idle_stays", 32'(mem_done) | 32'(memwait), 32'h0);

        // flush in ACCESS is ignored
        drive(1'b1, 1'b0, LW, 32'h400, '0, 1'b0, '0);
        tick();
        flush = 1'b1;
        drive(1'b1, 1'b0, LW, 32'h400, '0, 1'b0, '0);
        check("flush_access_strobe", 32'(dmem_ren), 32'h1);
        check("flush_access_memwait", 32'(memwait), 32'h1);
        tick();
        drive(1'b1, 1'b0, LW, 32'h400, '0, 1'b1, 32'hCAFEF00D);
        check("flush_access_hit", 32'(dmem_ren), 32'h1);
        tick();
        flush = 1'b0;
        idle();
        check("flush_access_done", 32'(mem_done), 32'h1);
        check("flush_access_load", loaddata, 32'hCAFEF00D);
        tick();

        // reset while in ACCESS
        drive(1'b0, 1'b1, SW, 32'h500, 32'h77, 1'b0, '0);
        check("rst_access_issue", 32'(dmem_wen), 32'h1);
        tick();
        rst = 1'b1;
        idle();
        tick();
        rst = 1'b0;
        #1;
        check("rst_access_memwait", 32'(memwait), 32'h0);
        check("rst_access_done", 32'(mem_done), 32'h0);
        check("rst_access_loaddata", loaddata, 32'h0);
        check("rst_access_strobe", 32'(dmem_wen), 32'h0);
        tick();

        // back-to-back LW then SW, both immediate hits
        drive(1'b1, 1'b0, LW, 32'h600, '0, 1'b1, 32'h11112222);
        check("b2b_lw_stall", 32'(memwait), 32'h1);
        check("b2b_lw_ren", 32'(dmem_ren), 32'h1);
        tick();
        drive(1'b1, 1'b0, LW, 32'h600, '0, 1'b0, '0);
        check("b2b_lw_done", 32'(mem_done), 32'h1);
        check("b2b_lw_done_ren", 32'(dmem_ren), 32'h0);
        check("b2b_lw_data", loaddata, 32'h11112222);
        tick();
        drive(1'b0, 1'b1, SW, 32'h604, 32'h55, 1'b1, '0);
        check("b2b_sw_stall", 32'(memwait), 32'h1);
        check("b2b_sw_wen", 32'(dmem_wen), 32'h1);
        check("b2b_sw_nodone", 32'(mem_done), 32'h0);
        tick();
        drive(1'b0, 1'b1, SW, 32'h604, 32'h55, 1'b0, '0);
        check("b2b_sw_done", 32'(mem_done), 32'h1);
        check("b2b_sw_done_wen", 32'(dmem_wen), 32'h0);
        check("b2b_sw_loaddata", loaddata, 32'h11112222);
        tick();

`ifdef LLSC_EN
        // SC with no link fails without touching the cache
        drive(1'b0, 1'b1, SC, 32'h700, 32'h9, 1'b1, '0);
        check("sc_nolink_wen", 32'(dmem_wen), 32'h0);
        check("sc_nolink_stall", 32'(memwait), 32'h1);
        tick();
        idle();
        check("sc_nolink_done", 32'(mem_done), 32'h1);
        check("sc_nolink_result", loaddata, 32'h0);
        tick();

        // LL 0x300 then SC 0x300 succeeds, second SC fails
        drive(1'b1, 1'b0, LL, 32'h300, '0, 1'b1, 32'hAAAA5555);
        tick();
        idle();
        check("ll_loaddata", loaddata, 32'hAAAA5555);
        tick();
        drive(1'b0, 1'b1, SC, 32'h300, 32'h7, 1'b1, '0);
        check("sc_ok_wen", 32'(dmem_wen), 32'h1);
        check("sc_ok_store", dmemstore, 32'h7);
        tick();
        idle();
        check("sc_ok_result", loaddata, 32'h1);
        tick();
        drive(1'b0, 1'b1, SC, 32'h300, 32'h7, 1'b1, '0);
        check("sc_cleared_wen", 32'(dmem_wen), 32'h0);
        tick();
        idle();
        check("sc_cleared_result", loaddata, 32'h0);
        tick();

        // invalidation between LL and SC
        drive(1'b1, 1'b0, LL, 32'h300, '0, 1'b1, 32'h12345678);
        tick();
        idle();
        tick();
        link_inval = 1'b1; link_inval_addr = 32'h300;
        idle();
        tick();
        link_inval = 1'b0;
        drive(1'b0, 1'b1, SC, 32'h300, 32'h7, 1'b1, '0);
        check("sc_inval_wen", 32'(dmem_wen), 32'h0);
        tick();
        idle();
        check("sc_inval_done", 32'(mem_done), 32'h1);
        check("sc_inval_result", loaddata, 32'h0);
        tick();

        // SC to a different address than the link
        drive(1'b1, 1'b0, LL, 32'h300, '0, 1'b1, 32'h0BADF00D);
        tick();
        idle();
        tick();
        drive(1'b0, 1'b1, SC, 32'h304, 32'h7, 1'b1, '0);
        check("sc_mismatch_wen", 32'(dmem_wen), 32'h0);
        tick();
        idle();
        check("sc_mismatch_result", loaddata, 32'h0);
        tick();

        // invalidation while the SC is waiting in ACCESS
        drive(1'b1, 1'b0, LL, 32'h300, '0, 1'b1, 32'h0F0F0F0F);
        tick();
        idle();
        tick();
        drive(1'b0, 1'b1, SC, 32'h300, 32'h7, 1'b0, '0);
        check("sc_late_issue", 32'(dmem_wen), 32'h1);
        tick();
        link_inval = 1'b1; link_inval_addr = 32'h300;
        drive(1'b0, 1'b1, SC, 32'h300, 32'h7, 1'b0, '0);
        tick();
        link_inval = 1'b0;
        drive(1'b0, 1'b1, SC, 32'h300, 32'h7, 1'b1, '0);
        check("sc_late_wen", 32'(dmem_wen), 32'h1);
        tick();
        idle();
        check("sc_late_done", 32'(mem_done), 32'h1);
        check("sc_late_result", loaddata, 32'h0);
        tick();
`else
        // without link support LL is a load and SC is a plain store
        drive(1'b1, 1'b0, LL, 32'h300, '0, 1'b1, 32'hAAAA5555);
        check("ll_as_lw_ren", 32'(dmem_ren), 32'h1);
        tick();
        idle();
        check("ll_as_lw_data", loaddata, 32'hAAAA5555);
        tick();
        drive(1'b0, 1'b1, SC, 32'h304, 32'h7, 1'b1, '0);
        check("sc_as_sw_wen", 32'(dmem_wen), 32'h1);
        check("sc_as_sw_addr", dmemaddr, 32'h304);
        tick();
        idle();
        check("sc_as_sw_done", 32'(mem_done), 32'h1);
        check("sc_as_sw_loaddata", loaddata, 32'hAAAA5555);
        tick();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
